// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem handshake, one-entry hold buffer for stalls,
// branch redirect (including drain of an in-flight request) and the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm16
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc4;
  logic [31:0] redirect, redirect_nxt;
  logic [31:0] hold_instr, hold_pc4;
  logic        hold_ld, id_ld;
  logic [31:0] id_src_instr, id_src_pc4;

  assign pc4 = pc + 32'd4;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    redirect_nxt = redirect;
    hold_ld      = 1'b0;
    id_ld        = 1'b0;
    id_src_instr = imem_rdata;
    id_src_pc4   = pc4;
    case (state)
      FETCH: begin
        if (branch_taken) begin
          if (imem_ack) pc_nxt = branch_target;
          else begin
            redirect_nxt = branch_target;
            state_nxt    = DRAIN;
          end
        end else if (imem_ack) begin
          pc_nxt = pc4;
          if (stall) begin
            hold_ld   = 1'b1;
            state_nxt = HOLD;
          end else begin
            id_ld = 1'b1;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_nxt    = branch_target;
          state_nxt = FETCH;
        end else if (!stall) begin
          id_ld        = 1'b1;
          id_src_instr = hold_instr;
          id_src_pc4   = hold_pc4;
          state_nxt    = FETCH;
        end
      end
      DRAIN: begin
        // The youngest redirect wins, even when it arrives with the draining ack.
        if (branch_taken) redirect_nxt = branch_target;
        if (imem_ack) begin
          pc_nxt    = redirect_nxt;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      redirect   <= 32'h0;
      hold_instr <= 32'h0;
      hold_pc4   <= 32'h0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      redirect <= redirect_nxt;
      if (hold_ld) begin
        hold_instr <= imem_rdata;
        hold_pc4   <= pc4;
      end
    end
  end

  // IF/ID: flush beats everything; an unstalled cycle with nothing to load is a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= 32'h0;
      id_pc4   <= 32'h0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_instr <= 32'h0;
    end else if (id_ld) begin
      id_valid <= 1'b1;
      id_instr <= id_src_instr;
      id_pc4   <= id_src_pc4;
    end else if (!stall) begin
      id_valid <= 1'b0;
    end
  end

  // Reset gating keeps the request low while rst_n is held, so no ack is owed.
  assign imem_req  = rst_n && (state != HOLD);
  assign imem_addr = pc;

  assign id_opcode = id_instr[31:26];
  assign id_rs     = id_instr[25:21];
  assign id_rt     = id_instr[20:16];
  assign id_rd     = id_instr[15:11];
  assign id_funct  = id_instr[5:0];
  assign id_imm16  = id_instr[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID words queued by the stimulus,
// popped and compared by a monitor whenever decode consumes a valid instruction.
module tb_fetch_stage;

  localparam logic [31:0] OVR_ADDR = 32'h0000_0010;
  localparam logic [31:0] OVR_DATA = 32'h2108_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc4;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm16;

  logic        imem_req2, imem_ack2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        id_valid2;
  logic [31:0] id_instr2, id_pc4_2;
  logic [5:0]  id_opcode2, id_funct2;
  logic [4:0]  id_rs2, id_rt2, id_rd2;
  logic [15:0] id_imm16_2;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  logic mem_en = 1'b0;
  int   lat = 0;
  int   cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == OVR_ADDR) ? OVR_DATA : (a ^ 32'hC0DE_0000);
  endfunction

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .id_imm16(id_imm16)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .stall(1'b0), .flush(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .id_valid(id_valid2), .id_instr(id_instr2), .id_pc4(id_pc4_2),
    .id_opcode(id_opcode2), .id_rs(id_rs2), .id_rt(id_rt2), .id_rd(id_rd2),
    .id_funct(id_funct2), .id_imm16(id_imm16_2)
  );

  // Memory with programmable latency: ack when the request has waited lat cycles.
  always @(posedge clk) begin
    if (!imem_req || imem_ack || !mem_en) cnt <= 0;
    else cnt <= cnt + 1;
  end

  always_comb begin
    imem_ack    = mem_en && imem_req && (cnt == lat);
    imem_rdata  = imem_ack ? word(imem_addr) : 32'hDEAD_BEEF;
    imem_ack2   = imem_req2;
    imem_rdata2 = word(imem_addr2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: decode consumes IF/ID when valid, not stalled and not flushed.
  always @(negedge clk) begin
    if (rst_n && id_valid && !stall && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got %h/%h expected none", id_instr, id_pc4);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_instr", id_instr, e[63:32]);
        chk("sb_pc4", id_pc4, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and zero-latency back-to-back fetch
    mem_en = 1'b1;
    lat = 0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    step();
    rst_n = 1'b1;
    exp_q.push_back({word(32'h0), 32'h4});
    exp_q.push_back({word(32'h4), 32'h8});
    exp_q.push_back({word(32'h8), 32'hC});
    @(negedge clk);
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    chk("first_valid", {31'h0, id_valid}, 32'h1);
    chk("wrap_addr1", imem_addr2, 32'h0);
    chk("wrap_pc4", id_pc4_2, 32'h0);
    step();
    step();
    mem_en = 1'b0;

    // Stall while an ack arrives: word goes to hold buffer, IF/ID frozen
    step();
    mem_en = 1'b1;
    exp_q.push_back({word(32'hC), 32'h10});
    exp_q.push_back({OVR_DATA, 32'h14});
    step();
    stall = 1'b1;
    step();
    @(negedge clk);
    chk("stall_instr0", id_instr, word(32'hC));
    chk("stall_pc4_0", id_pc4, 32'h10);
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    step();
    @(negedge clk);
    chk("stall_instr1", id_instr, word(32'hC));
    chk("stall_valid1", {31'h0, id_valid}, 32'h1);
    step();
    stall = 1'b0;
    @(negedge clk);
    chk("stall_instr2", id_instr, word(32'hC));
    step();
    mem_en = 1'b0;
    @(negedge clk);
    chk("hold_instr", id_instr, OVR_DATA);
    chk("hold_imm16", {16'h0, id_imm16}, 32'hFFFF);
    chk("hold_rt", {27'h0, id_rt}, 32'h8);
    chk("hold_rs", {27'h0, id_rs}, 32'h8);
    chk("hold_opcode", {26'h0, id_opcode}, 32'h8);
    chk("hold_rd", {27'h0, id_rd}, 32'h1F);
    chk("hold_funct", {26'h0, id_funct}, 32'h3F);

    // Flush with stall: bubble in IF/ID, PC untouched
    step();
    mem_en = 1'b1;
    step();
    stall = 1'b1;
    flush = 1'b1;
    mem_en = 1'b0;
    step();
    stall = 1'b0;
    flush = 1'b0;
    lat = 3;
    mem_en = 1'b1;
    @(negedge clk);
    chk("flush_valid", {31'h0, id_valid}, 32'h0);
    chk("flush_instr", id_instr, 32'h0);
    chk("flush_pc", imem_addr, 32'h18);

    // Branch while a slow request is in flight: drain, then redirect
    step();
    branch_taken = 1'b1;
    branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("drain_req", {31'h0, imem_req}, 32'h1);
    chk("drain_addr", imem_addr, 32'h18);
    step();
    step();
    @(negedge clk);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid", {31'h0, id_valid}, 32'h0);
    exp_q.push_back({word(32'h100), 32'h104});
    step();
    @(negedge clk);
    chk("redir_stable", imem_addr, 32'h100);
    repeat (3) step();
    mem_en = 1'b0;

    // Branch with ack in FETCH: fetched word discarded
    lat = 0;
    mem_en = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h200;
    step();
    lat = 3;
    branch_target = 32'h300;
    @(negedge clk);
    chk("br_ack_addr", imem_addr, 32'h200);
    chk("br_ack_valid", {31'h0, id_valid}, 32'h0);

    // Reset while draining: immediate clear, refetch from RESET_PC
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("drain2_req", {31'h0, imem_req}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_pc4", id_pc4, 32'h0);
    chk("mid_rst_instr", id_instr, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    step();
    rst_n = 1'b1;
    lat = 0;
    exp_q.push_back({word(32'h0), 32'h4});
    @(negedge clk);
    chk("post_rst_addr", imem_addr, 32'h0);
    step();
    mem_en = 1'b0;
    repeat (3) step();
    chk("sb_empty", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_req  output  1  instruction-memory request.
REQ-005 SHALL have port imem_addr  output  32  fetch address (current PC).
REQ-006 SHALL have port imem_ack  input  1  read data valid; any latency ≥0 cycles after request.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, sampled only when imem_ack=1.
REQ-008 SHALL have port stall  input  1  decode hazard stall; hold IF/ID and PC.
REQ-009 SHALL have port flush  input  1  convert IF/ID contents to bubble.
REQ-010 SHALL have port branch_taken  input  1  redirect fetch to branch_target.
REQ-011 SHALL have port branch_target  input  32  redirect address.
REQ-012 SHALL have port id_valid  output  1  IF/ID holds a real instruction.
REQ-013 SHALL have port id_instr  output  32  registered instruction.
REQ-014 SHALL have port id_pc4  output  32  address of id_instr plus 4.
REQ-015 SHALL have ports id_opcode 6, id_rs 5, id_rt 5, id_rd 5, id_funct 6, id_imm16 16, all outputs, bit-fields [31:26],[25:21],[20:16],[15:11],[5:0],[15:0] of id_instr; id_imm16 feeds the sign-extension stage.

Function
REQ-016 SHALL implement states FETCH, HOLD, DRAIN; imem_req=1 in FETCH and DRAIN, 0 in HOLD.
REQ-017 SHALL keep imem_addr=PC stable while imem_req=1 and imem_ack=0.
REQ-018 FETCH, ack=1, stall=0, branch_taken=0: SHALL load IF/ID (id_valid=1, id_instr=imem_rdata, id_pc4=PC+4) and PC<=PC+4 in the same edge; stay FETCH (back-to-back fetch, 1 instr/cycle with zero-latency memory).
REQ-019 FETCH, ack=1, stall=1, branch_taken=0: SHALL capture imem_rdata and PC+4 into a one-entry hold buffer, PC<=PC+4, go HOLD; IF/ID unchanged.
REQ-020 HOLD, stall=0: SHALL move hold buffer into IF/ID with id_valid=1, go FETCH; HOLD, stall=1: no change.
REQ-021 branch_taken=1 with ack=1 in FETCH, or in HOLD: SHALL discard fetched/buffered word, PC<=branch_target, go FETCH.
REQ-022 branch_taken=1 in FETCH with ack=0: SHALL latch branch_target into redirect register, go DRAIN.
REQ-023 DRAIN, ack=1: SHALL discard imem_rdata, PC<=redirect register, go FETCH; DRAIN, ack=0: wait; branch_taken in DRAIN SHALL overwrite redirect register.
REQ-024 branch_taken SHALL have priority over stall for PC and state update.
REQ-025 flush=1 SHALL set id_valid=0 and id_instr=32'h0 (NOP) on next edge, overriding stall and any IF/ID load; flush alone SHALL NOT alter PC, state or hold buffer.
REQ-026 stall=1 with flush=0 SHALL hold all IF/ID outputs unchanged.
REQ-027 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); PC[1:0] not checked.
REQ-028 All id_* outputs SHALL be registered; imem_req/imem_addr SHALL depend only on state registers.

Reset
REQ-029 rst_n=0 SHALL immediately set PC=RESET_PC, state=FETCH, id_valid=0, id_instr=0, id_pc4=0, hold buffer and redirect register cleared; imem_req SHALL be 0 while rst_n=0.
REQ-030 Reset mid-request SHALL abandon the outstanding request; any ack in the first cycle after deassertion belongs to the new RESET_PC request.

Verification
REQ-031 Reset, zero-latency memory returning addr-based words -> id_pc4 sequence 4,8,12; id_valid=1 from first edge after deassert.
REQ-032 Ack with stall=1 for 3 cycles, instr 32'h2108_FFFF -> IF/ID unchanged 3 cycles, then id_instr=32'h2108_FFFF, id_imm16=16'hFFFF, id_rt=8.
REQ-033 3-cycle latency memory, branch_taken target 32'h0000_0100 one cycle after req -> DRAIN, in-flight word never appears on id_*, next imem_addr=32'h100.
REQ-034 flush=1 with stall=1 -> id_valid=0, id_instr=0 next edge; PC unchanged.
REQ-035 RESET_PC=32'hFFFF_FFFC -> second imem_addr=32'h0000_0000.
REQ-036 rst_n low during DRAIN -> outputs cleared immediately, next fetch address RESET_PC.
